// File: rtl/seg_disp_multi.sv
// seg_disp_multi: multi-channel binary to 7-segment driver.
// Captures NUM_CH binary values on load, converts each channel in turn with a
// bit-serial double-dabble engine, then commits every HEX field in one edge so
// the display never shows a half-updated set of channels.
//
// state    | meaning
// S_IDLE   | waiting for load; hex holds last committed patterns
// S_CONV   | one double-dabble shift per clock, channels in sequence
// S_COMMIT | register all hex fields, pulse done, clear busy
module seg_disp_multi #(
  parameter int NUM_CH   = 3,
  parameter int IN_W     = 7,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         load,
  input  logic [NUM_CH*IN_W-1:0]       value,
  input  logic [NUM_CH-1:0]            blank_mask,
  output logic                         busy,
  output logic                         done,
  output logic [7*NUM_CH*DIGITS-1:0]   hex
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int DD_W  = BCD_W + IN_W;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIT_W = $clog2(IN_W + 1);
  localparam int HEX_W = 7 * NUM_CH * DIGITS;
  localparam logic [31:0] MAX_V = 32'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t                   state_q, state_d;
  logic [NUM_CH*IN_W-1:0]   val_q, val_d;
  logic [NUM_CH-1:0]        mask_q, mask_d;
  logic [NUM_CH-1:0]        ovf_q, ovf_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic [DD_W-1:0]          dd_q, dd_d;
  logic [NUM_CH*BCD_W-1:0]  stage_q, stage_d;
  logic [HEX_W-1:0]         hex_q, hex_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [DD_W-1:0]          dd_adj, dd_shift;
  logic [NUM_CH-1:0]        ovf_in;
  logic [HEX_W-1:0]         hex_enc;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // One double-dabble step: add 3 to nibbles >= 5, then shift left by one.
  always_comb begin
    dd_adj = dd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dd_q[IN_W+4*i +: 4] >= 4'd5)
        dd_adj[IN_W+4*i +: 4] = dd_q[IN_W+4*i +: 4] + 4'd3;
    end
    dd_shift = {dd_adj[DD_W-2:0], 1'b0};
  end

  // Overflow flags are taken from the raw inputs at load time.
  always_comb begin
    ovf_in = '0;
    for (int k = 0; k < NUM_CH; k++)
      ovf_in[k] = 32'(value[k*IN_W +: IN_W]) > MAX_V;
  end

  // Segment fields from staged BCD: mask, then overflow dash, then leading-zero blank.
  always_comb begin
    logic       nz;
    logic [3:0] dig;
    hex_enc = '1;
    nz      = 1'b0;
    dig     = 4'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      nz = 1'b0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
        dig = stage_q[(k*DIGITS+d)*4 +: 4];
        nz  = nz | (dig != 4'd0);
        if (mask_q[k])
          hex_enc[(k*DIGITS+d)*7 +: 7] = 7'h7F;
        else if (ovf_q[k])
          hex_enc[(k*DIGITS+d)*7 +: 7] = 7'b1111110;
        else if ((BLANK_LZ != 0) && (d != 0) && !nz)
          hex_enc[(k*DIGITS+d)*7 +: 7] = 7'h7F;
        else
          hex_enc[(k*DIGITS+d)*7 +: 7] = seg7(dig);
      end
    end
  end

  // Next-state logic for the controller and datapath registers.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    mask_d  = mask_q;
    ovf_d   = ovf_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    dd_d    = dd_q;
    stage_d = stage_q;
    hex_d   = hex_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          val_d   = value;
          mask_d  = blank_mask;
          ovf_d   = ovf_in;
          ch_d    = '0;
          bit_d   = '0;
          dd_d    = {{BCD_W{1'b0}}, value[IN_W-1:0]};
          busy_d  = 1'b1;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        dd_d  = dd_shift;
        bit_d = bit_q + BIT_W'(1);
        if (bit_q == BIT_W'(IN_W - 1)) begin
          stage_d[int'(ch_q)*BCD_W +: BCD_W] = dd_shift[DD_W-1 -: BCD_W];
          bit_d = '0;
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            state_d = S_COMMIT;
          end else begin
            ch_d = ch_q + CH_W'(1);
            dd_d = {{BCD_W{1'b0}}, val_q[(int'(ch_q)+1)*IN_W +: IN_W]};
          end
        end
      end
      S_COMMIT: begin
        hex_d   = hex_enc;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register bank; reset blanks the display and abandons any conversion.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      mask_q  <= '0;
      ovf_q   <= '0;
      ch_q    <= '0;
      bit_q   <= '0;
      dd_q    <= '0;
      stage_q <= '0;
      hex_q   <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      mask_q  <= mask_d;
      ovf_q   <= ovf_d;
      ch_q    <= ch_d;
      bit_q   <= bit_d;
      dd_q    <= dd_d;
      stage_q <= stage_d;
      hex_q   <= hex_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hex  = hex_q;

endmodule

// File: tb/tb_seg_disp_multi.sv
// Bench for seg_disp_multi: default, DIGITS=2 and BLANK_LZ=0 instances.
module tb_seg_disp_multi;

  logic        CLOCK_50;
  logic        reset;
  logic        load_a, load_b, load_c;
  logic [20:0] value_a, value_b, value_c;
  logic [2:0]  mask_a, mask_b, mask_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [62:0] hex_a, hex_c;
  logic [41:0] hex_b;

  int checks   = 0;
  int failures = 0;
  logic [62:0] exp_q[$];

  seg_disp_multi dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .load(load_a), .value(value_a),
    .blank_mask(mask_a), .busy(busy_a), .done(done_a), .hex(hex_a));

  seg_disp_multi #(.DIGITS(2)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .load(load_b), .value(value_b),
    .blank_mask(mask_b), .busy(busy_b), .done(done_b), .hex(hex_b));

  seg_disp_multi #(.BLANK_LZ(0)) dut_c (
    .CLOCK_50(CLOCK_50), .reset(reset), .load(load_c), .value(value_c),
    .blank_mask(mask_c), .busy(busy_c), .done(done_c), .hex(hex_c));

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [6:0] seg_ref(input int n);
    case (n)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  // Reference built from decimal division rather than BCD shifting.
  function automatic logic [62:0] model(input logic [20:0] v, input logic [2:0] m,
                                        input int digits, input int blz);
    logic [62:0] r;
    int vk, lim, p;
    logic [6:0] f;
    r = '0;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    lim = lim - 1;
    for (int k = 0; k < 3; k++) begin
      vk = int'(v[k*7 +: 7]);
      p = 1;
      for (int d = 0; d < digits; d++) begin
        if (m[k])                            f = 7'h7F;
        else if (vk > lim)                   f = 7'b1111110;
        else if (blz != 0 && d > 0 && vk < p) f = 7'h7F;
        else                                 f = seg_ref((vk / p) % 10);
        r[(k*digits+d)*7 +: 7] = f;
        p = p * 10;
      end
    end
    return r;
  endfunction

  function automatic int inst_digits(input int i);
    return (i == 1) ? 2 : 3;
  endfunction

  function automatic int inst_blz(input int i);
    return (i == 2) ? 0 : 1;
  endfunction

  function automatic logic get_done(input int i);
    case (i)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_busy(input int i);
    case (i)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic [62:0] get_hex(input int i);
    case (i)
      0: return hex_a;
      1: return {21'd0, hex_b};
      default: return hex_c;
    endcase
  endfunction

  // Pulse load for one cycle on the chosen instance and wait for done.
  task automatic run_conv(input int inst, input logic [20:0] v, input logic [2:0] m,
                          output int lat, output int busy_cnt,
                          output logic busy_at_done, output logic [62:0] hx);
    case (inst)
      0: begin value_a = v; mask_a = m; load_a = 1'b1; end
      1: begin value_b = v; mask_b = m; load_b = 1'b1; end
      default: begin value_c = v; mask_c = m; load_c = 1'b1; end
    endcase
    @(posedge CLOCK_50); #1;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    lat = -1;
    busy_at_done = 1'b1;
    hx = '0;
    busy_cnt = get_busy(inst) ? 1 : 0;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(posedge CLOCK_50); #1;
      if (get_done(inst)) begin
        lat = n;
        busy_at_done = get_busy(inst);
        hx = get_hex(inst);
      end else if (get_busy(inst)) begin
        busy_cnt++;
      end
    end
  endtask

  task automatic test_convert(input string name, input int inst,
                              input logic [20:0] v, input logic [2:0] m);
    int lat, bc;
    logic bd;
    logic [62:0] hx, exp;
    exp_q.push_back(model(v, m, inst_digits(inst), inst_blz(inst)));
    run_conv(inst, v, m, lat, bc, bd, hx);
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 22) begin
      failures++;
      $display("FAIL %s latency: got %0d want 22", name, lat);
    end
    checks++;
    if (bc !== 22) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d want 22", name, bc);
    end
    checks++;
    if (bd !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_at_done: got %b want 0", name, bd);
    end
    checks++;
    if (hx !== exp) begin
      failures++;
      $display("FAIL %s hex: got %h want %h", name, hx, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checks++;
    if (hex_a !== {63{1'b1}} || hex_b !== {42{1'b1}} || hex_c !== {63{1'b1}}) begin
      failures++;
      $display("FAIL reset_hex: got %h %h %h want all ones", hex_a, hex_b, hex_c);
    end
    checks++;
    if ({busy_a, busy_b, busy_c, done_a, done_b, done_c} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got busy=%b%b%b done=%b%b%b want 0",
               busy_a, busy_b, busy_c, done_a, done_b, done_c);
    end
    reset = 1'b0;
  endtask

  task automatic test_defaults;
    int lat, bc;
    logic bd;
    logic [62:0] hx;
    test_convert("defaults", 0, {7'd127, 7'd63, 7'd9}, 3'b000);
    hx = hex_a;
    checks++;
    if (hx[62:56] !== 7'b1001111 || hx[6:0] !== 7'b0000100 || hx[20:7] !== {7'h7F, 7'h7F}) begin
      failures++;
      $display("FAIL defaults_fields: got %h want ch2d2=1001111 ch0=7F,7F,0000100", hx);
    end
  endtask

  task automatic test_digits2;
    test_convert("digits2", 1, {7'd100, 7'd99, 7'd127}, 3'b000);
  endtask

  task automatic test_zero;
    test_convert("zero_blz1", 0, 21'd0, 3'b000);
    test_convert("zero_blz0", 2, 21'd0, 3'b000);
  endtask

  task automatic test_blank_mask;
    test_convert("blank_mask", 0, {7'd5, 7'd5, 7'd5}, 3'b010);
    test_convert("misc_blz0", 2, {7'd40, 7'd7, 7'd120}, 3'b001);
  endtask

  task automatic test_back_to_back;
    int dones, first;
    logic [62:0] hx, exp;
    exp_q.push_back(model({7'd56, 7'd34, 7'd12}, 3'b000, 3, 1));
    value_a = {7'd56, 7'd34, 7'd12}; mask_a = 3'b000; load_a = 1'b1;
    @(posedge CLOCK_50); #1;
    load_a = 1'b0;
    repeat (5) @(posedge CLOCK_50);
    #1;
    value_a = {7'd99, 7'd88, 7'd77}; mask_a = 3'b111; load_a = 1'b1;
    @(posedge CLOCK_50); #1;
    load_a = 1'b0;
    dones = 0; first = -1; hx = '0;
    for (int n = 7; n <= 45; n++) begin
      @(posedge CLOCK_50); #1;
      if (done_a) begin
        dones++;
        if (first < 0) begin first = n; hx = hex_a; end
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if (dones !== 1 || first !== 22) begin
      failures++;
      $display("FAIL ignore_load_done: got %0d pulses at %0d want 1 at 22", dones, first);
    end
    checks++;
    if (hx !== exp) begin
      failures++;
      $display("FAIL ignore_load_hex: got %h want %h", hx, exp);
    end
  endtask

  task automatic test_abort;
    int dones;
    dones = 0;
    value_a = {7'd3, 7'd2, 7'd1}; mask_a = 3'b000; load_a = 1'b1;
    @(posedge CLOCK_50); #1;
    load_a = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge CLOCK_50); #1;
      if (done_a) dones++;
    end
    reset = 1'b1;
    repeat (2) begin
      @(posedge CLOCK_50); #1;
      if (done_a) dones++;
    end
    checks++;
    if (hex_a !== {63{1'b1}} || busy_a !== 1'b0 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: got hex=%h busy=%b done=%b want all ones,0,0",
               hex_a, busy_a, done_a);
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL abort_done: got %0d pulses want 0", dones);
    end
    reset = 1'b0;
    test_convert("after_abort", 0, {7'd7, 7'd80, 7'd100}, 3'b000);
  endtask

  initial begin
    reset = 1'b1;
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
    value_a = '0; value_b = '0; value_c = '0;
    mask_a = '0; mask_b = '0; mask_c = '0;
    test_reset();
    test_defaults();
    test_digits2();
    test_zero();
    test_blank_mask();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
